fifo_push_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of a `fifo` instance among NUM_REQ producers.
- Grants one producer at a time for a bounded burst and gates pushes against FULL.
- Sequences FIFO flushes between bursts so a flush never splits a burst.
- Sits directly in front of `fifo`, driving its PUSH, DATA_IN and FLUSH.

---
 rtl/fifo_push_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers; bursts bounded by MAX_BURST.
// ACK/FIFO_PUSH are combinational (zero-latency push); FIFO_FULL or ENABLE low holds the grant without accepting.
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic                          FLUSH_REQ,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            ACK,
  output logic [NUM_REQ-1:0]            GRANT,
  output logic                          FIFO_PUSH,
  output logic [DATA_WIDTH-1:0]         FIFO_DATA_IN,
  input  logic                          FIFO_FULL,
  output logic                          FIFO_FLUSH,
  output logic                          FLUSH_DONE,
  output logic                          BUSY
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GRANT     = 2'd1,
    S_FLUSH     = 2'd2,
    S_FLUSH_ACK = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [IW-1:0]        last_q, last_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 flush_q, flush_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;
  logic                 accept_en;
  logic [3:0]           cnt_inc;
  logic                 burst_end;

  // Rotating priority: scan from the producer after the last one served, with wrap.
  always_comb begin : arb_pick
    int            j;
    logic [IW-1:0] cand;
    j        = 0;
    cand     = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IW'(j);
      if (!pick_vld && REQ[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign accept_en = (state_q == S_GRANT) & ENABLE & ~FIFO_FULL;
  assign ACK       = grant_q & REQ & {NUM_REQ{accept_en}};
  assign FIFO_PUSH = |ACK;

  always_comb begin : data_mux
    FIFO_DATA_IN = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) FIFO_DATA_IN = FIFO_DATA_IN | REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign cnt_inc   = cnt_q + 4'd1;
  // A burst ends on its marked last word, on reaching the cap, or when the owner walks away.
  assign burst_end = ~(|(grant_q & REQ)) |
                     (FIFO_PUSH & ((|(ACK & REQ_LAST)) | (cnt_inc == BURST_MAX)));

  always_comb begin : next_state
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (FLUSH_REQ) begin
          state_d = S_FLUSH;
        end else if (ENABLE && pick_vld) begin
          state_d           = S_GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          cnt_d             = '0;
        end
      end
      S_GRANT: begin
        if (FIFO_PUSH) cnt_d = cnt_inc;
        if (burst_end) begin
          state_d = S_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      S_FLUSH:     state_d = S_FLUSH_ACK;
      S_FLUSH_ACK: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    flush_d = (state_d == S_FLUSH);
    done_d  = (state_d == S_FLUSH_ACK);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign GRANT      = grant_q;
  assign FIFO_FLUSH = flush_q;
  assign FLUSH_DONE = done_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: producer drivers, a queue standing in for the fifo, and a per-cycle reference model.
module tb_fifo_push_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic               CLK;
  logic               RESET;
  logic               ENABLE;
  logic               FLUSH_REQ;
  logic [NR-1:0]      REQ;
  logic [NR-1:0]      REQ_LAST;
  logic [NR*DW-1:0]   REQ_DATA;
  logic [NR-1:0]      ACK;
  logic [NR-1:0]      GRANT;
  logic               FIFO_PUSH;
  logic [DW-1:0]      FIFO_DATA_IN;
  logic               FIFO_FULL;
  logic               FIFO_FLUSH;
  logic               FLUSH_DONE;
  logic               BUSY;

  fifo_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .FLUSH_REQ(FLUSH_REQ),
    .REQ(REQ), .REQ_LAST(REQ_LAST), .REQ_DATA(REQ_DATA),
    .ACK(ACK), .GRANT(GRANT), .FIFO_PUSH(FIFO_PUSH), .FIFO_DATA_IN(FIFO_DATA_IN),
    .FIFO_FULL(FIFO_FULL), .FIFO_FLUSH(FIFO_FLUSH), .FLUSH_DONE(FLUSH_DONE), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Producer scripts: word k of producer i is base + k*step; last flag on final word if enabled.
  int          p_len[NR];
  int          p_sent[NR];
  logic [31:0] p_base[NR];
  logic [31:0] p_step[NR];
  bit          p_last[NR];
  logic [NR-1:0] ack_seen;

  // Observation logs and the fifo stand-in.
  int          glog[$];
  int          alog[$];
  logic [31:0] fq[$];
  int          cyc, last_ack_cyc, flush_cyc, done_cyc, flush_cnt;
  logic [NR-1:0] prev_grant;

  // Reference model state.
  int m_owner, m_words, m_phase, m_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no event expected event within cycle budget", nm);
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      REQ[i]             = (p_sent[i] < p_len[i]);
      REQ_DATA[i*DW +: DW] = p_base[i] + p_step[i] * 32'(p_sent[i]);
      REQ_LAST[i]        = p_last[i] && (p_sent[i] == p_len[i] - 1);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    for (int i = 0; i < NR; i++) if (ack_seen[i]) p_sent[i]++;
    apply();
  endtask

  task automatic start_p(input int i, input int len, input logic [31:0] base,
                         input logic [31:0] stp, input bit last);
    p_len[i]  = len;
    p_sent[i] = 0;
    p_base[i] = base;
    p_step[i] = stp;
    p_last[i] = last;
    apply();
  endtask

  task automatic clear_producers();
    for (int i = 0; i < NR; i++) begin
      p_len[i] = 0; p_sent[i] = 0; p_base[i] = '0; p_step[i] = 32'd1; p_last[i] = 1'b0;
    end
    apply();
  endtask

  task automatic do_reset();
    RESET = 1'b0; FLUSH_REQ = 1'b0; FIFO_FULL = 1'b0; ENABLE = 1'b1;
    clear_producers();
    step();
    step();
    glog.delete(); alog.delete(); fq.delete();
    flush_cnt = 0; last_ack_cyc = -1; flush_cyc = -1; done_cyc = -1;
    RESET = 1'b1;
  endtask

  task automatic wait_quiet(input string nm, input int budget);
    int n;
    n = 0;
    while ((REQ != '0 || BUSY) && n < budget) begin step(); n++; end
    if (n >= budget) timeout(nm);
    step();
  endtask

  task automatic wait_ack(input string nm, input int entry, input int cnt);
    int n;
    n = 0;
    while (!(alog.size() > entry && alog[entry] >= cnt) && n < 100) begin step(); n++; end
    if (n >= 100) timeout(nm);
  endtask

  // Per-cycle compare against the model, sampled mid-cycle while inputs are stable.
  always @(negedge CLK) begin : compare
    logic [NR-1:0] eg, ea;
    logic [DW-1:0] ed;
    int nxt, j;
    cyc++;
    if (!RESET) begin
      m_owner = -1; m_words = 0; m_phase = 0; m_last = NR - 1;
      chk("rst_grant", 64'(GRANT), 64'd0);
      chk("rst_ack", 64'(ACK), 64'd0);
      chk("rst_busy", 64'(BUSY), 64'd0);
      chk("rst_flush", 64'({FIFO_FLUSH, FLUSH_DONE}), 64'd0);
      ack_seen = '0;
    end else begin
      eg  = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
      ea  = (m_owner >= 0 && REQ[m_owner] && ENABLE && !FIFO_FULL) ? eg : '0;
      ed  = (m_owner >= 0) ? REQ_DATA[m_owner*DW +: DW] : '0;
      chk("grant", 64'(GRANT), 64'(eg));
      chk("ack", 64'(ACK), 64'(ea));
      chk("push", 64'(FIFO_PUSH), 64'(ea != '0));
      chk("data", 64'(FIFO_DATA_IN), 64'(ed));
      chk("fifo_flush", 64'(FIFO_FLUSH), 64'(m_phase == 1));
      chk("flush_done", 64'(FLUSH_DONE), 64'(m_phase == 2));
      chk("busy", 64'(BUSY), 64'(m_owner >= 0 || m_phase != 0));

      if (GRANT != '0 && prev_grant == '0) begin
        for (int i = 0; i < NR; i++) if (GRANT[i]) glog.push_back(i);
        alog.push_back(0);
      end
      if (ACK != '0) begin
        if (alog.size() > 0) alog[alog.size()-1]++;
        last_ack_cyc = cyc;
      end
      if (FIFO_FLUSH) begin fq.delete(); flush_cnt++; flush_cyc = cyc; end
      if (FLUSH_DONE) done_cyc = cyc;
      if (FIFO_PUSH) fq.push_back(FIFO_DATA_IN);
      ack_seen = ACK;

      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2) m_phase = 0;
      else if (m_owner >= 0) begin
        if (ea != '0) m_words++;
        if (!REQ[m_owner] || (ea != '0 && (REQ_LAST[m_owner] || m_words == MB))) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end else if (FLUSH_REQ) m_phase = 1;
      else if (ENABLE && REQ != '0) begin
        nxt = -1;
        for (int k = 1; k <= NR; k++) begin
          j = (m_last + k) % NR;
          if (REQ[j] && nxt < 0) nxt = j;
        end
        m_owner = nxt;
        m_words = 0;
      end
    end
    prev_grant = GRANT;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; prev_grant = '0; ack_seen = '0;
    RESET = 1'b0; ENABLE = 1'b1; FLUSH_REQ = 1'b0; FIFO_FULL = 1'b0;
    REQ = '0; REQ_LAST = '0; REQ_DATA = '0;
    do_reset();
    chk("reset_grant_lit", 64'(GRANT), 64'd0);
    chk("reset_busy_lit", 64'(BUSY), 64'd0);

    // Single producer, three words, last on the third.
    start_p(0, 3, 32'hAAAA_5555, 32'h1111_1111, 1'b1);
    step();
    chk("t1_grant_after_1", 64'(GRANT), 64'h1);
    wait_quiet("t1_quiet", 50);
    chk("t1_words", 64'(fq.size()), 64'd3);
    if (fq.size() == 3) begin
      chk("t1_pop0", 64'(fq.pop_front()), 64'hAAAA_5555);
      chk("t1_pop1", 64'(fq.pop_front()), 64'hBBBB_6666);
      chk("t1_pop2", 64'(fq.pop_front()), 64'hCCCC_7777);
    end
    chk("t1_bursts", 64'(alog.size()), 64'd1);

    // All four requesting continuously, bursts capped at MAX_BURST; brief ENABLE drop.
    do_reset();
    for (int i = 0; i < NR; i++) start_p(i, 8, 32'(i) << 28, 32'd1, 1'b0);
    repeat (6) step();
    ENABLE = 1'b0;
    step(); step();
    ENABLE = 1'b1;
    wait_quiet("t2_quiet", 300);
    chk("t2_ngrants", 64'(glog.size()), 64'd8);
    if (glog.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t2_order%0d", i), 64'(glog[i]), 64'(i % 4));
        chk($sformatf("t2_len%0d", i), 64'(alog[i]), 64'd4);
      end
    end
    chk("t2_words", 64'(fq.size()), 64'd32);
    if (fq.size() == 32) begin
      chk("t2_fq4", 64'(fq[4]), 64'h1000_0000);
      chk("t2_fq16", 64'(fq[16]), 64'h0000_0004);
    end

    // FIFO_FULL held for three cycles in the middle of producer 2's burst.
    do_reset();
    start_p(2, 4, 32'h2000_0000, 32'd1, 1'b0);
    wait_ack("t3_first_ack", 0, 1);
    FIFO_FULL = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_full_ack", 64'(ACK), 64'd0);
      chk("t3_full_grant", 64'(GRANT), 64'h4);
      step();
    end
    FIFO_FULL = 1'b0;
    wait_quiet("t3_quiet", 50);
    chk("t3_bursts", 64'(glog.size()), 64'd1);
    if (alog.size() == 1) chk("t3_len", 64'(alog[0]), 64'd4);
    chk("t3_words", 64'(fq.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < fq.size()) chk($sformatf("t3_word%0d", k), 64'(fq[k]), 64'h2000_0000 + 64'(k));

    // Flush requested mid-burst is deferred until the burst completes.
    do_reset();
    start_p(1, 4, 32'h1000_0000, 32'd1, 1'b1);
    wait_ack("t4_first_ack", 0, 1);
    FLUSH_REQ = 1'b1;
    begin
      int n;
      n = 0;
      while (!FLUSH_DONE && n < 100) begin step(); n++; end
      if (n >= 100) timeout("t4_done");
    end
    FLUSH_REQ = 1'b0;
    repeat (3) step();
    if (alog.size() == 1) chk("t4_len", 64'(alog[0]), 64'd4);
    chk("t4_flush_gap", 64'(flush_cyc - last_ack_cyc), 64'd2);
    chk("t4_done_gap", 64'(done_cyc - flush_cyc), 64'd1);
    chk("t4_flush_cnt", 64'(flush_cnt), 64'd1);
    chk("t4_fifo_empty", 64'(fq.size()), 64'd0);

    // Producer 3 abandons after two words; producer 0 is served next.
    do_reset();
    start_p(3, 2, 32'h3000_0000, 32'd1, 1'b0);
    wait_ack("t5_grant3", 0, 0);
    start_p(0, 2, 32'h0000_1000, 32'd1, 1'b1);
    wait_quiet("t5_quiet", 50);
    chk("t5_ngrants", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      chk("t5_first", 64'(glog[0]), 64'd3);
      chk("t5_second", 64'(glog[1]), 64'd0);
      chk("t5_len3", 64'(alog[0]), 64'd2);
    end

    // Async reset in the middle of a burst restores producer 0's priority.
    do_reset();
    start_p(0, 4, 32'h0000_0100, 32'd1, 1'b0);
    wait_quiet("t6_pre", 50);
    start_p(0, 4, 32'h0000_0200, 32'd1, 1'b0);
    wait_ack("t6_mid", 1, 1);
    RESET = 1'b0;
    #1;
    chk("t6_rst_grant", 64'(GRANT), 64'd0);
    chk("t6_rst_busy", 64'(BUSY), 64'd0);
    chk("t6_rst_flush", 64'(FIFO_FLUSH), 64'd0);
    chk("t6_rst_push", 64'(FIFO_PUSH), 64'd0);
    clear_producers();
    step();
    glog.delete(); alog.delete();
    start_p(0, 2, 32'h0000_0300, 32'd1, 1'b1);
    start_p(1, 2, 32'h0000_0400, 32'd1, 1'b1);
    step();
    RESET = 1'b1;
    wait_quiet("t6_quiet", 50);
    chk("t6_ngrants", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      chk("t6_first", 64'(glog[0]), 64'd0);
      chk("t6_second", 64'(glog[1]), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
